// File: rtl/ogfx_vram_arbiter.sv
// ogfx_vram_arbiter
//   Shares the single Video-RAM port between the display-refresh reader,
//   the GPU drawing engine and the CPU path. Refresh has priority over
//   GPU/CPU, and GPU/CPU alternate through a round-robin pointer.
//   Compile option OGFX_VRAM_ARB_STARVE_EN adds a per-requester stall counter
//   that lets a GPU/CPU request override refresh after STARVE_MAX stalled cycles.
//   Without the option, continuous refresh can block GPU/CPU indefinitely.
module ogfx_vram_arbiter #(
   parameter int AW         = 17,
   parameter int STARVE_MAX = 15
) (
   input  logic          mclk,
   input  logic          puc_rst_n,
   // refresh (read-only)
   input  logic [AW-1:0] ref_addr_i,
   input  logic          ref_cen_i,
   output logic [15:0]   ref_dout_o,
   output logic          ref_dout_rdy_nxt_o,
   // GPU
   input  logic [AW-1:0] gpu_addr_i,
   input  logic          gpu_cen_i,
   input  logic          gpu_wen_i,
   input  logic [15:0]   gpu_din_i,
   output logic [15:0]   gpu_dout_o,
   output logic          gpu_dout_rdy_nxt_o,
   // CPU
   input  logic [AW-1:0] cpu_addr_i,
   input  logic          cpu_cen_i,
   input  logic          cpu_wen_i,
   input  logic [15:0]   cpu_din_i,
   output logic [15:0]   cpu_dout_o,
   output logic          cpu_dout_rdy_nxt_o,
   // Video-RAM
   output logic [AW-1:0] vid_ram_addr_o,
   output logic          vid_ram_cen_o,
   output logic          vid_ram_wen_o,
   output logic [15:0]   vid_ram_din_o,
   input  logic [15:0]   vid_ram_dout_i
);

   localparam logic [1:0] TAG_NONE = 2'd0;
   localparam logic [1:0] TAG_REF  = 2'd1;
   localparam logic [1:0] TAG_GPU  = 2'd2;
   localparam logic [1:0] TAG_CPU  = 2'd3;

   logic       pend_ref, pend_gpu, pend_cpu;
   logic       starv_gpu, starv_cpu;
   logic       gnt_ref, gnt_gpu, gnt_cpu;
   logic       rr_q, rr_d;
   logic [1:0] tag_q, tag_d;

   // Reset masks every request so nothing reaches the RAM while it is held
   assign pend_ref = puc_rst_n & ~ref_cen_i;
   assign pend_gpu = puc_rst_n & ~gpu_cen_i;
   assign pend_cpu = puc_rst_n & ~cpu_cen_i;

`ifdef OGFX_VRAM_ARB_STARVE_EN
   localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

   logic [7:0] gpu_cnt_q, gpu_cnt_d;
   logic [7:0] cpu_cnt_q, cpu_cnt_d;

   // Count consecutive stalled cycles; a grant or a withdrawn request restarts it
   always_comb begin
      gpu_cnt_d = 8'd0;
      cpu_cnt_d = 8'd0;
      if (pend_gpu && !gnt_gpu)
         gpu_cnt_d = (gpu_cnt_q == 8'hFF) ? gpu_cnt_q : gpu_cnt_q + 8'd1;
      if (pend_cpu && !gnt_cpu)
         cpu_cnt_d = (cpu_cnt_q == 8'hFF) ? cpu_cnt_q : cpu_cnt_q + 8'd1;
   end

   // Stall counter registers
   always_ff @(posedge mclk or negedge puc_rst_n) begin
      if (!puc_rst_n) begin
         gpu_cnt_q <= 8'd0;
         cpu_cnt_q <= 8'd0;
      end else begin
         gpu_cnt_q <= gpu_cnt_d;
         cpu_cnt_q <= cpu_cnt_d;
      end
   end

   assign starv_gpu = pend_gpu & (gpu_cnt_q >= STARVE_LIM);
   assign starv_cpu = pend_cpu & (cpu_cnt_q >= STARVE_LIM);
`else
   assign starv_gpu = 1'b0;
   assign starv_cpu = 1'b0;
`endif

   // Grant: starved GPU/CPU, then refresh, then plain GPU/CPU; rr_q breaks GPU/CPU ties
   always_comb begin
      gnt_ref = 1'b0;
      gnt_gpu = 1'b0;
      gnt_cpu = 1'b0;
      if (starv_gpu || starv_cpu) begin
         if (starv_gpu && starv_cpu) begin
            gnt_gpu = ~rr_q;
            gnt_cpu =  rr_q;
         end else begin
            gnt_gpu = starv_gpu;
            gnt_cpu = starv_cpu;
         end
      end else if (pend_ref) begin
         gnt_ref = 1'b1;
      end else if (pend_gpu && pend_cpu) begin
         gnt_gpu = ~rr_q;
         gnt_cpu =  rr_q;
      end else begin
         gnt_gpu = pend_gpu;
         gnt_cpu = pend_cpu;
      end
   end

   // RAM port mux; idle port is parked at cen=1, wen=1, addr=0, din=0
   always_comb begin
      vid_ram_cen_o  = 1'b1;
      vid_ram_wen_o  = 1'b1;
      vid_ram_addr_o = '0;
      vid_ram_din_o  = 16'h0000;
      if (gnt_ref) begin
         vid_ram_cen_o  = 1'b0;
         vid_ram_addr_o = ref_addr_i;
      end else if (gnt_gpu) begin
         vid_ram_cen_o  = 1'b0;
         vid_ram_wen_o  = gpu_wen_i;
         vid_ram_addr_o = gpu_addr_i;
         vid_ram_din_o  = gpu_din_i;
      end else if (gnt_cpu) begin
         vid_ram_cen_o  = 1'b0;
         vid_ram_wen_o  = cpu_wen_i;
         vid_ram_addr_o = cpu_addr_i;
         vid_ram_din_o  = cpu_din_i;
      end
   end

   assign ref_dout_rdy_nxt_o = gnt_ref;
   assign gpu_dout_rdy_nxt_o = gnt_gpu;
   assign cpu_dout_rdy_nxt_o = gnt_cpu;

   // Next pointer and owner tag; writes return no data so they tag NONE
   always_comb begin
      rr_d  = rr_q;
      tag_d = TAG_NONE;
      if (gnt_gpu) rr_d = 1'b1;
      if (gnt_cpu) rr_d = 1'b0;
      if (gnt_ref)                  tag_d = TAG_REF;
      else if (gnt_gpu && gpu_wen_i) tag_d = TAG_GPU;
      else if (gnt_cpu && cpu_wen_i) tag_d = TAG_CPU;
   end

   // Pointer and tag registers; reset drops any in-flight read
   always_ff @(posedge mclk or negedge puc_rst_n) begin
      if (!puc_rst_n) begin
         rr_q  <= 1'b0;
         tag_q <= TAG_NONE;
      end else begin
         rr_q  <= rr_d;
         tag_q <= tag_d;
      end
   end

   // Read data goes only to the requester that owned last cycle's read
   assign ref_dout_o = (tag_q == TAG_REF) ? vid_ram_dout_i : 16'h0000;
   assign gpu_dout_o = (tag_q == TAG_GPU) ? vid_ram_dout_i : 16'h0000;
   assign cpu_dout_o = (tag_q == TAG_CPU) ? vid_ram_dout_i : 16'h0000;

endmodule

// File: tb/tb_ogfx_vram_arbiter.sv
// Bench for ogfx_vram_arbiter: directed scenarios then random traffic, every
// cycle compared against a transaction-level model of the arbitration rules.
// Works with or without OGFX_VRAM_ARB_STARVE_EN defined.
module tb_ogfx_vram_arbiter;
   localparam int AW   = 17;
   localparam int SMAX = 4;

   logic          mclk = 1'b0;
   logic          puc_rst_n;
   always #5 mclk = ~mclk;

   // requester table: 0 = REF, 1 = GPU, 2 = CPU
   logic          rq_pend [3];
   logic          rq_keep [3];
   logic [AW-1:0] rq_addr [3];
   logic          rq_wen  [3];
   logic [15:0]   rq_din  [3];

   logic          ref_cen, gpu_cen, cpu_cen;
   assign ref_cen = ~rq_pend[0];
   assign gpu_cen = ~rq_pend[1];
   assign cpu_cen = ~rq_pend[2];

   logic [15:0]   ref_dout_o, gpu_dout_o, cpu_dout_o;
   logic          ref_dout_rdy_nxt_o, gpu_dout_rdy_nxt_o, cpu_dout_rdy_nxt_o;
   logic [AW-1:0] vid_ram_addr_o;
   logic          vid_ram_cen_o, vid_ram_wen_o;
   logic [15:0]   vid_ram_din_o;
   logic [15:0]   vid_ram_dout_i;

   ogfx_vram_arbiter #(.AW(AW), .STARVE_MAX(SMAX)) dut (
      .mclk               (mclk),
      .puc_rst_n          (puc_rst_n),
      .ref_addr_i         (rq_addr[0]),
      .ref_cen_i          (ref_cen),
      .ref_dout_o         (ref_dout_o),
      .ref_dout_rdy_nxt_o (ref_dout_rdy_nxt_o),
      .gpu_addr_i         (rq_addr[1]),
      .gpu_cen_i          (gpu_cen),
      .gpu_wen_i          (rq_wen[1]),
      .gpu_din_i          (rq_din[1]),
      .gpu_dout_o         (gpu_dout_o),
      .gpu_dout_rdy_nxt_o (gpu_dout_rdy_nxt_o),
      .cpu_addr_i         (rq_addr[2]),
      .cpu_cen_i          (cpu_cen),
      .cpu_wen_i          (rq_wen[2]),
      .cpu_din_i          (rq_din[2]),
      .cpu_dout_o         (cpu_dout_o),
      .cpu_dout_rdy_nxt_o (cpu_dout_rdy_nxt_o),
      .vid_ram_addr_o     (vid_ram_addr_o),
      .vid_ram_cen_o      (vid_ram_cen_o),
      .vid_ram_wen_o      (vid_ram_wen_o),
      .vid_ram_din_o      (vid_ram_din_o),
      .vid_ram_dout_i     (vid_ram_dout_i)
   );

   function automatic logic [15:0] init_val(input logic [AW-1:0] a);
      int v;
      v = int'(a) * 40503;
      return v[15:0] ^ 16'h5A5A;
   endfunction

   // Video-RAM macro: one-cycle read latency
   logic [15:0] ram_mem [int];
   always @(posedge mclk) begin
      if (!vid_ram_cen_o) begin
         vid_ram_dout_i <= ram_mem.exists(int'(vid_ram_addr_o)) ? ram_mem[int'(vid_ram_addr_o)]
                                                               : init_val(vid_ram_addr_o);
         if (!vid_ram_wen_o) ram_mem[int'(vid_ram_addr_o)] = vid_ram_din_o;
      end
   end

   // reference model state
   logic [15:0] shadow [int];
   int          m_rr;        // 0: GPU preferred on a tie
   int          m_wait [3];  // consecutive pending-not-served cycles
   int          m_owner;     // requester whose read data is due, -1 none
   logic [15:0] m_data;
   int          obs_gnt;     // DUT grant seen this cycle (3 = none)

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] sh_rd(input logic [AW-1:0] a);
      return shadow.exists(int'(a)) ? shadow[int'(a)] : init_val(a);
   endfunction

   // Who should win this cycle, straight from the priority rules
   function automatic int pick();
      bit sg, sc;
      if (!puc_rst_n) return -1;
`ifdef OGFX_VRAM_ARB_STARVE_EN
      sg = rq_pend[1] && (m_wait[1] >= SMAX);
      sc = rq_pend[2] && (m_wait[2] >= SMAX);
`else
      sg = 1'b0;
      sc = 1'b0;
`endif
      if (sg && sc) return (m_rr == 0) ? 1 : 2;
      if (sg) return 1;
      if (sc) return 2;
      if (rq_pend[0]) return 0;
      if (rq_pend[1] && rq_pend[2]) return (m_rr == 0) ? 1 : 2;
      if (rq_pend[1]) return 1;
      if (rq_pend[2]) return 2;
      return -1;
   endfunction

   task automatic post(input int id, input logic [AW-1:0] a, input logic wen,
                       input logic [15:0] d, input logic keep);
      rq_pend[id] = 1'b1;
      rq_keep[id] = keep;
      rq_addr[id] = a;
      rq_wen[id]  = (id == 0) ? 1'b1 : wen;
      rq_din[id]  = d;
   endtask

   // One clock: check outputs mid-cycle, advance the model, react to grants
   task automatic cycle();
      int          g;
      logic [15:0] e_ref, e_gpu, e_cpu;
      @(negedge mclk);
      g = pick();
      obs_gnt = ref_dout_rdy_nxt_o ? 0 : gpu_dout_rdy_nxt_o ? 1 : cpu_dout_rdy_nxt_o ? 2 : 3;
      chk("ram_cen",  32'(vid_ram_cen_o), 32'(g < 0));
      chk("ram_wen",  32'(vid_ram_wen_o), 32'((g <= 0) ? 1'b1 : rq_wen[g]));
      chk("ram_addr", 32'(vid_ram_addr_o), 32'((g < 0) ? '0 : rq_addr[g]));
      if (g != 0)
         chk("ram_din", 32'(vid_ram_din_o), 32'((g < 0) ? 16'h0 : rq_din[g]));
      chk("ref_rdy", 32'(ref_dout_rdy_nxt_o), 32'(g == 0));
      chk("gpu_rdy", 32'(gpu_dout_rdy_nxt_o), 32'(g == 1));
      chk("cpu_rdy", 32'(cpu_dout_rdy_nxt_o), 32'(g == 2));
      e_ref = (puc_rst_n && m_owner == 0) ? m_data : 16'h0;
      e_gpu = (puc_rst_n && m_owner == 1) ? m_data : 16'h0;
      e_cpu = (puc_rst_n && m_owner == 2) ? m_data : 16'h0;
      chk("ref_dout", 32'(ref_dout_o), 32'(e_ref));
      chk("gpu_dout", 32'(gpu_dout_o), 32'(e_gpu));
      chk("cpu_dout", 32'(cpu_dout_o), 32'(e_cpu));
      if (!puc_rst_n) begin
         m_rr = 0; m_owner = -1;
         for (int i = 0; i < 3; i++) m_wait[i] = 0;
      end else begin
         m_owner = -1;
         if (g >= 0) begin
            if (g == 0 || rq_wen[g]) begin
               m_owner = g;
               m_data  = sh_rd(rq_addr[g]);
            end else begin
               shadow[int'(rq_addr[g])] = rq_din[g];
            end
         end
         if (g == 1) m_rr = 1;
         if (g == 2) m_rr = 0;
         for (int i = 1; i < 3; i++) begin
            if (g == i) begin
`ifdef OGFX_VRAM_ARB_STARVE_EN
               chk("wait_bound", 32'(m_wait[i] <= SMAX + 1), 32'd1);
`endif
               m_wait[i] = 0;
            end else if (rq_pend[i]) m_wait[i]++;
            else m_wait[i] = 0;
         end
      end
      @(posedge mclk);
      #1;
      if (puc_rst_n && g >= 0 && !rq_keep[g]) rq_pend[g] = 1'b0;
   endtask

   // REF saturating the port, GPU waiting: note the cycle the GPU gets in
   task automatic starve_probe(input string tag);
      int got;
      got = 0;
      post(0, 17'h00020, 1'b1, 16'h0, 1'b1);
      post(1, 17'h00070, 1'b1, 16'h0, 1'b0);
      for (int n = 1; n <= 20; n++) begin
         cycle();
         if (obs_gnt == 1) begin got = n; break; end
      end
`ifdef OGFX_VRAM_ARB_STARVE_EN
      chk(tag, 32'(got), 32'(SMAX + 1));
`else
      chk(tag, 32'(got), 32'd0);
`endif
      cycle();
      rq_pend[0] = 1'b0; rq_keep[0] = 1'b0;
      repeat (2) cycle();
   endtask

   initial begin
      logic [11:0] seq;
      for (int i = 0; i < 3; i++) begin
         rq_pend[i] = 1'b0; rq_keep[i] = 1'b0; rq_addr[i] = '0;
         rq_wen[i] = 1'b1; rq_din[i] = 16'h0; m_wait[i] = 0;
      end
      m_rr = 0; m_owner = -1; m_data = 16'h0; obs_gnt = 3;
      puc_rst_n = 1'b1;
      #2 puc_rst_n = 1'b0;

      // reset holds off a pending CPU read
      post(2, 17'h00040, 1'b1, 16'h0, 1'b0);
      repeat (2) cycle();
      puc_rst_n = 1'b1;
      repeat (2) cycle();

      // single GPU write, then read it back
      post(1, 17'h00010, 1'b0, 16'hA5A5, 1'b0);
      cycle();
      chk("gpu_write_grant", 32'(obs_gnt), 32'd1);
      cycle();
      post(1, 17'h00010, 1'b1, 16'h0, 1'b0);
      cycle();
      chk("gpu_readback", 32'(gpu_dout_o), 32'h0000A5A5);
      cycle();

      // REF and CPU reads together: REF first, CPU next
      post(0, 17'h00020, 1'b1, 16'h0, 1'b0);
      post(2, 17'h00030, 1'b1, 16'h0, 1'b0);
      cycle();
      chk("ref_first", 32'(obs_gnt), 32'd0);
      cycle();
      chk("cpu_second", 32'(obs_gnt), 32'd2);
      cycle();

      // reset lands while a CPU read is in flight
      post(2, 17'h00030, 1'b1, 16'h0, 1'b0);
      cycle();
      puc_rst_n = 1'b0;
      #1;
      chk("rst_cpu_dout", 32'(cpu_dout_o), 32'd0);
      cycle();
      puc_rst_n = 1'b1;
      cycle();

      // rr pointer returns to GPU after reset even if CPU was next
      post(1, 17'h00050, 1'b1, 16'h0, 1'b0);
      post(2, 17'h00051, 1'b1, 16'h0, 1'b0);
      cycle();
      puc_rst_n = 1'b0;
      #1;
      chk("rst_cen", 32'(vid_ram_cen_o), 32'd1);
      repeat (2) cycle();
      puc_rst_n = 1'b1;
      post(1, 17'h00050, 1'b1, 16'h0, 1'b1);
      post(2, 17'h00051, 1'b1, 16'h0, 1'b1);
      seq = '0;
      for (int i = 0; i < 6; i++) begin
         cycle();
         seq = {seq[9:0], 2'(obs_gnt)};
      end
      chk("rr_alternate", 32'(seq), 32'h666);
      for (int i = 1; i < 3; i++) begin rq_pend[i] = 1'b0; rq_keep[i] = 1'b0; end
      cycle();

      // starvation guard against continuous refresh
      starve_probe("starve_first");

      // REF withdrawn while GPU/CPU are stalled behind it
      post(0, 17'h00022, 1'b1, 16'h0, 1'b1);
      post(1, 17'h00060, 1'b1, 16'h0, 1'b0);
      post(2, 17'h00061, 1'b0, 16'h1234, 1'b0);
      repeat (5) cycle();
      rq_pend[0] = 1'b0; rq_keep[0] = 1'b0;
      repeat (3) cycle();
      starve_probe("starve_after_clear");

      // random traffic
      for (int c = 0; c < 400; c++) begin
         if (!rq_pend[0] && $urandom_range(3) != 0)
            post(0, AW'($urandom_range(63)), 1'b1, 16'h0, 1'b0);
         for (int i = 1; i < 3; i++) begin
            if (!rq_pend[i]) begin
               if ($urandom_range(2) != 0)
                  post(i, AW'($urandom_range(63)), 1'($urandom_range(1)), 16'($urandom), 1'b0);
            end else if ($urandom_range(15) == 0) begin
               rq_pend[i] = 1'b0;
            end
         end
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
